// File: rtl/mealy_pattern_bank.sv
// mealy_pattern_bank
// -------------------------------------------------------------------------
// Watches a serial bit stream and compares the most recent W accepted bits
// against N independently programmable patterns. A channel hit is a
// combinational Mealy output in the same cycle as the final bit, and a
// registered copy follows one cycle later. A hit does not flush the
// history, so overlapping occurrences are all reported.
//
// Optional feature (macro MEALY_PATTERN_BANK_COUNT_EN): adds one saturating
// CW-bit hit counter per channel on the hit_count port.
//
// Ports:
//   clock      system clock, all state changes on posedge
//   reset_n    asynchronous active-low reset
//   i          serial data bit
//   i_valid    qualifier for i
//   clear      synchronous flush of history and fill state
//   pattern    N*W bits, channel k in [k*W +: W], MSB is the oldest bit
//   enable     per-channel enable mask
//   o          per-channel Mealy hit, same cycle as the last bit
//   o_q        o delayed by one clock
//   primed     history holds W-1 valid bits (FSM is in RUN)
//   dbg_state  raw FSM state (0 = FILL, 1 = RUN) for checkers
//   hit_count  N*CW bits, channel k in [k*CW +: CW] (optional feature only)
//
// Stream qualifier: there is no backpressure. A bit is consumed on a
// posedge exactly when i_valid=1 and clear=0; in any other cycle i is
// ignored, the history holds and no channel can hit.
module mealy_pattern_bank #(
  parameter int W  = 3,
  parameter int N  = 2,
  parameter int CW = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           i,
  input  logic           i_valid,
  input  logic           clear,
  input  logic [N*W-1:0] pattern,
  input  logic [N-1:0]   enable,
  output logic [N-1:0]   o,
  output logic [N-1:0]   o_q,
  output logic           primed,
  output logic           dbg_state
`ifdef MEALY_PATTERN_BANK_COUNT_EN
  ,
  output logic [N*CW-1:0] hit_count
`endif
);

  localparam int FW = $clog2(W);
  localparam logic [FW-1:0] FILL_LAST = FW'(W - 1);

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [FW-1:0] fill, fill_n;
  logic [W-2:0]  hist, hist_n, hist_shift;
  logic [W-1:0]  window;

  // With W=2 the history is a single bit, so the shift degenerates to a load.
  generate
    if (W == 2) begin : g_shift_w2
      assign hist_shift = i;
    end else begin : g_shift_wide
      assign hist_shift = {hist[W-3:0], i};
    end
  endgenerate

  assign window = {hist, i};

  always_comb begin
    state_n = state;
    fill_n  = fill;
    hist_n  = hist;
    if (clear) begin
      state_n = FILL;
      fill_n  = '0;
      hist_n  = '0;
    end else if (i_valid) begin
      hist_n = hist_shift;
      if (state == FILL) begin
        fill_n = fill + 1'b1;
        if (fill_n == FILL_LAST) state_n = RUN;
      end
    end
  end

  // reset_n gates o directly so the hit drops the moment reset asserts,
  // not at the next edge.
  always_comb begin
    o = '0;
    for (int k = 0; k < N; k++) begin
      o[k] = reset_n & i_valid & ~clear & (state == RUN) & enable[k] &
             (window == pattern[k*W +: W]);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
      fill  <= '0;
      hist  <= '0;
      o_q   <= '0;
    end else begin
      state <= state_n;
      fill  <= fill_n;
      hist  <= hist_n;
      o_q   <= o;
    end
  end

  assign primed    = (state == RUN);
  assign dbg_state = state;

`ifdef MEALY_PATTERN_BANK_COUNT_EN
  // o is already forced low during clear, but clear is tested first so a
  // flush always wins regardless of how o is qualified.
  generate
    for (genvar k = 0; k < N; k++) begin : g_cnt
      logic [CW-1:0] cnt;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (o[k] && (cnt != {CW{1'b1}})) begin
          cnt <= cnt + 1'b1;
        end
      end
      assign hit_count[k*CW +: CW] = cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mealy_pattern_bank.sv
// Bench for mealy_pattern_bank: main instance W=3 N=2 CW=8 plus a small
// W=2 N=1 CW=2 instance for the short-pattern and saturation cases.
module tb_mealy_pattern_bank;
  localparam int W  = 3;
  localparam int N  = 2;
  localparam int CW = 8;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // main DUT signals
  logic           i = 1'b0, i_valid = 1'b0, clear = 1'b0;
  logic [N*W-1:0] pattern = '0;
  logic [N-1:0]   enable = '0;
  logic [N-1:0]   o, o_q;
  logic           primed, dbg_state;
`ifdef MEALY_PATTERN_BANK_COUNT_EN
  logic [N*CW-1:0] hit_count;
`endif

  // W=2 DUT signals
  logic       i2 = 1'b0, v2 = 1'b0, c2 = 1'b0;
  logic [1:0] pat2 = '0;
  logic [0:0] en2 = '0;
  logic [0:0] o2, oq2;
  logic       pr2, dbg2;
`ifdef MEALY_PATTERN_BANK_COUNT_EN
  logic [1:0] hc2;
`endif

  mealy_pattern_bank #(.W(W), .N(N), .CW(CW)) dut (
    .clock(clock), .reset_n(reset_n), .i(i), .i_valid(i_valid), .clear(clear),
    .pattern(pattern), .enable(enable), .o(o), .o_q(o_q), .primed(primed),
    .dbg_state(dbg_state)
`ifdef MEALY_PATTERN_BANK_COUNT_EN
    , .hit_count(hit_count)
`endif
  );

  mealy_pattern_bank #(.W(2), .N(1), .CW(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .i(i2), .i_valid(v2), .clear(c2),
    .pattern(pat2), .enable(en2), .o(o2), .o_q(oq2), .primed(pr2),
    .dbg_state(dbg2)
`ifdef MEALY_PATTERN_BANK_COUNT_EN
    , .hit_count(hc2)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int total = 0;
  int bad = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] oq_q[$];
  logic [15:0]  m_hist;
  int           m_cnt;
  int           m_hc[N];
  logic [N-1:0] last_o;

  task automatic model_reset();
    m_hist = '0;
    m_cnt  = 0;
    for (int k = 0; k < N; k++) m_hc[k] = 0;
  endtask

  function automatic logic [N-1:0] model_o(input logic ib, input logic iv, input logic clr);
    logic [N-1:0] r;
    logic [W-1:0] w;
    r = '0;
    w = {m_hist[W-2:0], ib};
    for (int k = 0; k < N; k++)
      if (iv && !clr && (m_cnt == W - 1) && enable[k] && (w == pattern[k*W +: W]))
        r[k] = 1'b1;
    return r;
  endfunction

  task automatic model_step(input logic ib, input logic iv, input logic clr, input logic [N-1:0] e);
    if (clr) begin
      model_reset();
    end else begin
      for (int k = 0; k < N; k++)
        if (e[k] && m_hc[k] < (1 << CW) - 1) m_hc[k]++;
      if (iv) begin
        m_hist = {m_hist[14:0], ib};
        if (m_cnt < W - 1) m_cnt++;
      end
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: check registered outputs left by the previous edge,
  // drive new inputs, then check the combinational hit mid-cycle.
  task automatic cycle(input logic ib, input logic iv, input logic clr);
    logic [N-1:0] e, want;
    @(posedge clock); #1;
    if (oq_q.size() != 0) begin
      want = oq_q.pop_front();
      total++;
      if (o_q !== want) begin bad++; $display("FAIL o_q: got %b want %b", o_q, want); end
    end
    total++;
    if (primed !== 1'(m_cnt == W - 1)) begin
      bad++; $display("FAIL primed: got %b want %b", primed, m_cnt == W - 1);
    end
`ifdef MEALY_PATTERN_BANK_COUNT_EN
    for (int k = 0; k < N; k++) begin
      total++;
      if (hit_count[k*CW +: CW] !== CW'(m_hc[k])) begin
        bad++; $display("FAIL hit_count[%0d]: got %0d want %0d", k, hit_count[k*CW +: CW], m_hc[k]);
      end
    end
`endif
    i = ib; i_valid = iv; clear = clr;
    e = model_o(ib, iv, clr);
    exp_q.push_back(e);
    oq_q.push_back(e);
    #3;
    want = exp_q.pop_front();
    total++;
    if (o !== want) begin bad++; $display("FAIL o: got %b want %b", o, want); end
    last_o = o;
    model_step(ib, iv, clr, e);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n);
    for (int b = n - 1; b >= 0; b--) cycle(bits[b], 1'b1, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; i = 1'b1; i_valid = 1'b0; clear = 1'b0;
    #12;
    total++; if (o !== '0)     begin bad++; $display("FAIL reset_o: got %b want 00", o); end
    total++; if (o_q !== '0)   begin bad++; $display("FAIL reset_o_q: got %b want 00", o_q); end
    total++; if (primed !== 0) begin bad++; $display("FAIL reset_primed: got %b want 0", primed); end
    total++; if (pr2 !== 0)    begin bad++; $display("FAIL reset_primed2: got %b want 0", pr2); end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    exp_q.delete(); oq_q.delete(); oq_q.push_back('0);
  endtask

  task automatic test_basic();
    int h0, h1;
    h0 = 0; h1 = 0;
    pattern = {3'b101, 3'b010}; enable = 2'b11;
    for (int b = 9; b >= 0; b--) begin
      logic [9:0] s;
      s = 10'b0110101011;
      cycle(s[b], 1'b1, 1'b0);
      h0 += int'(last_o[0]);
      h1 += int'(last_o[1]);
    end
    cycle(1'b0, 1'b0, 1'b0);
    total++; if (h1 !== 3) begin bad++; $display("FAIL basic_hits1: got %0d want 3", h1); end
    total++; if (h0 !== 2) begin bad++; $display("FAIL basic_hits0: got %0d want 2", h0); end
  endtask

  task automatic test_fill_boundary();
    cycle(1'b0, 1'b0, 1'b1);
    send_bits(32'b10, 2);
    cycle(1'b1, 1'b1, 1'b0);
    total++; if (last_o !== 2'b10) begin bad++; $display("FAIL fill_hit: got %b want 10", last_o); end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_valid_gaps();
    int pulses;
    pulses = 0;
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0); cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      cycle(1'(g), 1'b0, 1'b0);
      pulses += int'(last_o[1]);
    end
    cycle(1'b1, 1'b1, 1'b0);
    pulses += int'(last_o[1]);
    total++; if (pulses !== 1) begin bad++; $display("FAIL gap_pulses: got %0d want 1", pulses); end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    send_bits(32'b10, 2);
    cycle(1'b1, 1'b1, 1'b1);
    send_bits(32'b101, 3);
    total++; if (last_o !== 2'b10) begin bad++; $display("FAIL clear_rehit: got %b want 10", last_o); end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] e;
    cycle(1'b0, 1'b0, 1'b1);
    send_bits(32'b101, 3);
    @(posedge clock); #1;
    e = oq_q.pop_front();
    total++; if (o_q !== e) begin bad++; $display("FAIL mid_o_q_pre: got %b want %b", o_q, e); end
    i = 1'b0; i_valid = 1'b1; clear = 1'b0;
    e = model_o(1'b0, 1'b1, 1'b0);
    #1;
    total++; if (o !== e) begin bad++; $display("FAIL mid_o_pre: got %b want %b", o, e); end
    reset_n = 1'b0;
    #1;
    total++; if (o !== '0)     begin bad++; $display("FAIL mid_o_rst: got %b want 00", o); end
    total++; if (o_q !== '0)   begin bad++; $display("FAIL mid_o_q_rst: got %b want 00", o_q); end
    total++; if (primed !== 0) begin bad++; $display("FAIL mid_primed_rst: got %b want 0", primed); end
    @(negedge clock);
    i_valid = 1'b0;
    reset_n = 1'b1;
    model_reset();
    exp_q.delete(); oq_q.delete(); oq_q.push_back('0);
    send_bits(32'b101, 3);
    total++; if (last_o !== 2'b10) begin bad++; $display("FAIL mid_rehit: got %b want 10", last_o); end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_mask_overlap();
    pattern = {3'b101, 3'b101}; enable = 2'b01;
    cycle(1'b0, 1'b0, 1'b1);
    for (int b = 4; b >= 0; b--) begin
      cycle(1'(b[0] == 1'b0), 1'b1, 1'b0);
      if (b == 2 || b == 0) begin
        total++;
        if (last_o !== 2'b01) begin bad++; $display("FAIL mask_hit: got %b want 01", last_o); end
      end
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if (n % 40 == 0) begin
        pattern = N*W'($urandom_range(0, (1 << (N*W)) - 1));
        enable  = N'($urandom_range(0, (1 << N) - 1));
      end
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0));
    end
    cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_w2_sat();
    logic filled, prev, e, prev_e;
    int cnt;
    filled = 1'b0; prev = 1'b0; prev_e = 1'b0; cnt = 0;
    pat2 = 2'b11; en2 = 1'b1;
    @(posedge clock); #1;
    c2 = 1'b1; v2 = 1'b0;
    for (int n = 0; n < 7; n++) begin
      @(posedge clock); #1;
      total++; if (pr2 !== filled) begin bad++; $display("FAIL w2_primed: got %b want %b", pr2, filled); end
      total++; if (oq2[0] !== prev_e) begin bad++; $display("FAIL w2_o_q: got %b want %b", oq2, prev_e); end
`ifdef MEALY_PATTERN_BANK_COUNT_EN
      total++; if (hc2 !== 2'(cnt)) begin bad++; $display("FAIL w2_count: got %0d want %0d", hc2, cnt); end
`endif
      c2 = 1'b0; i2 = 1'b1; v2 = (n < 6);
      e = v2 & filled & prev & i2;
      #3;
      total++; if (o2[0] !== e) begin bad++; $display("FAIL w2_o: got %b want %b", o2, e); end
      if (e && cnt < 3) cnt++;
      if (v2) begin prev = i2; filled = 1'b1; end
      prev_e = e;
    end
`ifdef MEALY_PATTERN_BANK_COUNT_EN
    total++; if (hc2 !== 2'd3) begin bad++; $display("FAIL w2_sat_final: got %0d want 3", hc2); end
`endif
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_fill_boundary();
    test_valid_gaps();
    test_clear();
    test_reset_mid();
    test_mask_overlap();
    test_random();
    test_w2_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
